// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the N-slave interconnect: transfer/response codes,
// default-slave state encoding and data-phase select markers.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01,
    RespRetry = 2'b10,
    RespSplit = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    DsIdle = 2'b00,
    DsErr1 = 2'b01,
    DsErr2 = 2'b10
  } ds_state_e;

  // Data-phase select markers; real slave indices are 0..7.
  localparam logic [3:0] DSEL_NONE = 4'hF;
  localparam logic [3:0] DSEL_DEF  = 4'hE;

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Default slave: answers every accepted unmapped NONSEQ/SEQ transfer with a
// two-cycle ERROR (wait+ERROR, then ready+ERROR).
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic unmapped_i,
  output logic hready_o,
  output logic hresp_o
);

  ds_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DsIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DsIdle:  if (accept_i && unmapped_i) state_d = DsErr1;
      DsErr1:  state_d = DsErr2;
      // Back-to-back unmapped transfers skip the idle state.
      DsErr2:  state_d = (accept_i && unmapped_i) ? DsErr1 : DsIdle;
      default: state_d = DsIdle;
    endcase
  end

  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (state_q)
      DsErr1: begin
        hready_o = 1'b0;
        hresp_o  = 1'b1;
      end
      DsErr2: begin
        hready_o = 1'b1;
        hresp_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_lite_ns.sv
// AHB-Lite interconnect, one master to NUM_SLAVES slaves: base/mask decode,
// registered data-phase response mux, built-in default slave and error capture.
module ahb_lite_ns
  import ahb_lite_pkg::*;
#(
  parameter int                      NUM_SLAVES = 2,
  parameter int                      DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK  = {32'hF000_0000, 32'hF000_0000},
  parameter int                      ERRCNT_W   = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic                         HMASTLOCK,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic [NUM_SLAVES-1:0]        hsel_s,
  output logic [31:0]                  haddr_s,
  output logic [1:0]                   htrans_s,
  output logic                         hwrite_s,
  output logic [2:0]                   hsize_s,
  output logic [2:0]                   hburst_s,
  output logic [3:0]                   hprot_s,
  output logic                         hmastlock_s,
  output logic [DATA_W-1:0]            hwdata_s,
  output logic                         hready_s,
  input  logic [NUM_SLAVES-1:0]        hready_resp_s,
  input  logic [2*NUM_SLAVES-1:0]      hresp_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic                         err_clr,
  output logic                         err_valid,
  output logic [31:0]                  err_addr,
  output logic [3:0]                   err_slave,
  output logic [ERRCNT_W-1:0]          err_cnt
);

  logic [3:0]          dec_idx;
  logic [3:0]          dsel_q, dsel_d;
  logic [31:0]         daddr_q, daddr_d;
  logic                trans_active, unmapped, accept;
  logic                ds_hready, ds_hresp;
  logic                err_event;
  logic                err_valid_q;
  logic [31:0]         err_addr_q;
  logic [3:0]          err_slave_q, dsel_slave;
  logic [ERRCNT_W-1:0] err_cnt_q;

  assign haddr_s     = HADDR;
  assign htrans_s    = HTRANS;
  assign hwrite_s    = HWRITE;
  assign hsize_s     = HSIZE;
  assign hburst_s    = HBURST;
  assign hprot_s     = HPROT;
  assign hmastlock_s = HMASTLOCK;
  assign hwdata_s    = HWDATA;
  assign hready_s    = HREADY;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    dec_idx = DSEL_DEF;
    hsel_s  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) dec_idx = 4'(i);
    end
    for (int i = 0; i < NUM_SLAVES; i++) hsel_s[i] = (dec_idx == 4'(i));
  end

  assign trans_active = (HTRANS == TransNonseq) || (HTRANS == TransSeq);
  assign unmapped     = (dec_idx == DSEL_DEF);
  assign accept       = HREADY && trans_active;

  assign dsel_d  = HREADY ? (trans_active ? dec_idx : DSEL_NONE) : dsel_q;
  assign daddr_d = HREADY ? HADDR : daddr_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q  <= DSEL_NONE;
      daddr_q <= '0;
    end else begin
      dsel_q  <= dsel_d;
      daddr_q <= daddr_d;
    end
  end

  ahb_lite_default_slave u_default_slave (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .accept_i   (accept),
    .unmapped_i (unmapped),
    .hready_o   (ds_hready),
    .hresp_o    (ds_hresp)
  );

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (dsel_q == DSEL_DEF) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dsel_q == 4'(i)) begin
          HREADY = hready_resp_s[i];
          HRESP  = |hresp_s[2*i +: 2];
          HRDATA = hrdata_s[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  // Completion cycle of an error response; the ERR1 wait cycle is not counted.
  assign err_event  = HRESP && HREADY;
  assign dsel_slave = (dsel_q == DSEL_DEF) ? 4'(NUM_SLAVES) : dsel_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_slave_q <= '0;
      err_cnt_q   <= '0;
    end else if (err_event) begin
      if (!err_valid_q || err_clr) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= daddr_q;
        err_slave_q <= dsel_slave;
      end
      if (err_clr) begin
        err_cnt_q <= ERRCNT_W'(1);
      end else if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
        err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
      end
    end else if (err_clr) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_slave_q <= '0;
      err_cnt_q   <= '0;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_slave = err_slave_q;
  assign err_cnt   = err_cnt_q;

endmodule
